// File: rtl/cursor_ctrl.sv
// Input stage for the paint display: syncs and debounces the board buttons and switches,
// then turns them into cursor position, colour, tool enable and brush size.
module cursor_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 30000000,
  parameter int REPEAT_PERIOD   = 2000000,
  parameter int H_MAX           = 640,
  parameter int V_MAX           = 480,
  parameter int STEP            = 1,
  parameter int X_INIT          = 320,
  parameter int Y_INIT          = 240
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_color,
  input  logic       sw_tool,
  input  logic       sw_size,
  output logic [9:0] X_POS,
  output logic [9:0] Y_POS,
  output logic [2:0] color,
  output logic       tool_on,
  output logic       size_sel
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);
  localparam int NBTN   = 5;
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} axis_state_e;

  // Bit order: up, down, left, right, colour (debounced), tool, size (sync only)
  logic [6:0]      raw;
  logic [6:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NBTN-1:0] db_q, db_d;
  logic [DB_W-1:0] db_cnt_q [NBTN];
  logic [DB_W-1:0] db_cnt_d [NBTN];
  logic            color_prev_q, color_prev_d;
  logic [2:0]      color_q, color_d;

  // Axis 0 is X, axis 1 is Y; directions encoded 2'b01 = +1, 2'b11 = -1, 2'b00 = none
  axis_state_e     state_q [2];
  axis_state_e     state_d [2];
  logic [RP_W-1:0] rp_cnt_q [2];
  logic [RP_W-1:0] rp_cnt_d [2];
  logic [1:0]      last_dir_q [2];
  logic [1:0]      last_dir_d [2];
  logic [9:0]      pos_q [2];
  logic [9:0]      pos_d [2];
  logic [1:0]      dir [2];
  logic            step [2];

  assign raw = {sw_size, sw_tool, btn_color, btn_right, btn_left, btn_down, btn_up};

  function automatic logic [9:0] clamp_step(input logic [9:0] pos, input logic [1:0] d,
                                            input logic signed [10:0] lim);
    logic signed [10:0] p;
    logic signed [10:0] nxt;
    p = signed'({1'b0, pos});
    if (d == 2'b11) nxt = (p < STEP_S) ? 11'sd0 : p - STEP_S;
    else            nxt = (p + STEP_S > lim) ? lim : p + STEP_S;
    return 10'(nxt);
  endfunction

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < NBTN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) db_d[i] = sync2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end

    color_prev_d = db_q[4];
    color_d      = color_q;
    if (db_q[4] && !color_prev_q) color_d = color_q + 3'd1;

    dir[0] = (db_q[2] && !db_q[3]) ? 2'b11 : ((db_q[3] && !db_q[2]) ? 2'b01 : 2'b00);
    dir[1] = (db_q[0] && !db_q[1]) ? 2'b11 : ((db_q[1] && !db_q[0]) ? 2'b01 : 2'b00);

    // A reversal is any non-zero direction that differs from the last stepped one
    for (int a = 0; a < 2; a++) begin
      state_d[a]    = state_q[a];
      rp_cnt_d[a]   = rp_cnt_q[a];
      last_dir_d[a] = last_dir_q[a];
      pos_d[a]      = pos_q[a];
      step[a]       = 1'b0;
      case (state_q[a])
        IDLE: begin
          if (dir[a] != 2'b00) begin
            step[a]     = 1'b1;
            rp_cnt_d[a] = '0;
            state_d[a]  = HOLD;
          end
        end
        HOLD: begin
          if (dir[a] == 2'b00) begin
            rp_cnt_d[a] = '0;
            state_d[a]  = IDLE;
          end else if (dir[a] != last_dir_q[a]) begin
            step[a]     = 1'b1;
            rp_cnt_d[a] = '0;
          end else if (rp_cnt_q[a] == RP_W'(REPEAT_DELAY - 1)) begin
            step[a]     = 1'b1;
            rp_cnt_d[a] = '0;
            state_d[a]  = REPEAT;
          end else begin
            rp_cnt_d[a] = rp_cnt_q[a] + RP_W'(1);
          end
        end
        REPEAT: begin
          if (dir[a] == 2'b00) begin
            rp_cnt_d[a] = '0;
            state_d[a]  = IDLE;
          end else if (dir[a] != last_dir_q[a]) begin
            step[a]     = 1'b1;
            rp_cnt_d[a] = '0;
            state_d[a]  = HOLD;
          end else if (rp_cnt_q[a] == RP_W'(REPEAT_PERIOD - 1)) begin
            step[a]     = 1'b1;
            rp_cnt_d[a] = '0;
          end else begin
            rp_cnt_d[a] = rp_cnt_q[a] + RP_W'(1);
          end
        end
        default: begin
          rp_cnt_d[a] = '0;
          state_d[a]  = IDLE;
        end
      endcase
      if (step[a]) begin
        last_dir_d[a] = dir[a];
        pos_d[a] = clamp_step(pos_q[a], dir[a], (a == 0) ? 11'(H_MAX - 1) : 11'(V_MAX - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_q         <= '0;
      color_prev_q <= 1'b0;
      color_q      <= 3'd7;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= '0;
      for (int a = 0; a < 2; a++) begin
        state_q[a]    <= IDLE;
        rp_cnt_q[a]   <= '0;
        last_dir_q[a] <= '0;
      end
      pos_q[0] <= 10'(X_INIT);
      pos_q[1] <= 10'(Y_INIT);
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_q         <= db_d;
      color_prev_q <= color_prev_d;
      color_q      <= color_d;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int a = 0; a < 2; a++) begin
        state_q[a]    <= state_d[a];
        rp_cnt_q[a]   <= rp_cnt_d[a];
        last_dir_q[a] <= last_dir_d[a];
        pos_q[a]      <= pos_d[a];
      end
    end
  end

  assign X_POS    = pos_q[0];
  assign Y_POS    = pos_q[1];
  assign color    = color_q;
  assign tool_on  = sync2_q[5];
  assign size_sel = sync2_q[6];

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl with short debounce/repeat timing.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cursor_ctrl;

  logic       clk, clr;
  logic       btn_up, btn_down, btn_left, btn_right, btn_color, sw_tool, sw_size;
  logic [9:0] X_POS, Y_POS;
  logic [2:0] color;
  logic       tool_on, size_sel;

  int checks = 0;
  int errors = 0;

  cursor_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .clr(clr),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_color(btn_color), .sw_tool(sw_tool), .sw_size(sw_size),
    .X_POS(X_POS), .Y_POS(Y_POS), .color(color), .tool_on(tool_on), .size_sel(size_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Each tick crosses one rising edge and ends on the next falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    clr = 1'b0;
    tick(2);
    clr = 1'b1;
  endtask

  // A raw change seen at rising edge k debounces at k+5 and moves the cursor at k+6
  task automatic test_reset();
    do_reset();
    checks++; if (X_POS !== 10'd320) begin errors++; $display("[TB] FAIL reset_x got %0d exp 320", X_POS); end
    checks++; if (Y_POS !== 10'd240) begin errors++; $display("[TB] FAIL reset_y got %0d exp 240", Y_POS); end
    checks++; if (color !== 3'd7) begin errors++; $display("[TB] FAIL reset_color got %0d exp 7", color); end
    checks++; if (tool_on !== 1'b0) begin errors++; $display("[TB] FAIL reset_tool got %0b exp 0", tool_on); end
    checks++; if (size_sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_size got %0b exp 0", size_sel); end
  endtask

  task automatic test_tap();
    btn_right = 1'b1;
    tick(6);
    checks++; if (X_POS !== 10'd320) begin errors++; $display("[TB] FAIL tap_early got %0d exp 320", X_POS); end
    tick(1);
    checks++; if (X_POS !== 10'd321) begin errors++; $display("[TB] FAIL tap_step got %0d exp 321", X_POS); end
    tick(1);
    btn_right = 1'b0;
    tick(20);
    checks++; if (X_POS !== 10'd321) begin errors++; $display("[TB] FAIL tap_once got %0d exp 321", X_POS); end
    checks++; if (Y_POS !== 10'd240) begin errors++; $display("[TB] FAIL tap_y got %0d exp 240", Y_POS); end
    btn_right = 1'b1;
    tick(2);
    btn_right = 1'b0;
    tick(20);
    checks++; if (X_POS !== 10'd321) begin errors++; $display("[TB] FAIL glitch got %0d exp 321", X_POS); end
  endtask

  task automatic test_hold();
    do_reset();
    btn_up = 1'b1;
    tick(6);
    checks++; if (Y_POS !== 10'd240) begin errors++; $display("[TB] FAIL hold_pre got %0d exp 240", Y_POS); end
    tick(1);
    checks++; if (Y_POS !== 10'd239) begin errors++; $display("[TB] FAIL hold_first got %0d exp 239", Y_POS); end
    tick(9);
    checks++; if (Y_POS !== 10'd239) begin errors++; $display("[TB] FAIL hold_delay got %0d exp 239", Y_POS); end
    tick(1);
    checks++; if (Y_POS !== 10'd238) begin errors++; $display("[TB] FAIL hold_second got %0d exp 238", Y_POS); end
    tick(2);
    checks++; if (Y_POS !== 10'd238) begin errors++; $display("[TB] FAIL rep_gap got %0d exp 238", Y_POS); end
    tick(1);
    checks++; if (Y_POS !== 10'd237) begin errors++; $display("[TB] FAIL rep_1 got %0d exp 237", Y_POS); end
    tick(3);
    checks++; if (Y_POS !== 10'd236) begin errors++; $display("[TB] FAIL rep_2 got %0d exp 236", Y_POS); end
    tick(3);
    checks++; if (Y_POS !== 10'd235) begin errors++; $display("[TB] FAIL rep_3 got %0d exp 235", Y_POS); end
    tick(15);
    checks++; if (Y_POS !== 10'd230) begin errors++; $display("[TB] FAIL rep_8 got %0d exp 230", Y_POS); end
    btn_up = 1'b0;
    tick(6);
    checks++; if (Y_POS !== 10'd228) begin errors++; $display("[TB] FAIL release got %0d exp 228", Y_POS); end
    tick(20);
    checks++; if (Y_POS !== 10'd228) begin errors++; $display("[TB] FAIL stopped got %0d exp 228", Y_POS); end
    checks++; if (X_POS !== 10'd320) begin errors++; $display("[TB] FAIL hold_x got %0d exp 320", X_POS); end
  endtask

  task automatic test_clamp();
    do_reset();
    btn_left = 1'b1;
    tick(1100);
    checks++; if (X_POS !== 10'd0) begin errors++; $display("[TB] FAIL clamp_x0 got %0d exp 0", X_POS); end
    tick(20);
    checks++; if (X_POS !== 10'd0) begin errors++; $display("[TB] FAIL clamp_x0_hold got %0d exp 0", X_POS); end
    btn_left = 1'b0;
    do_reset();
    btn_down = 1'b1;
    tick(1000);
    checks++; if (Y_POS !== 10'd479) begin errors++; $display("[TB] FAIL clamp_ymax got %0d exp 479", Y_POS); end
    tick(20);
    checks++; if (Y_POS !== 10'd479) begin errors++; $display("[TB] FAIL clamp_ymax_hold got %0d exp 479", Y_POS); end
    btn_down = 1'b0;
    tick(20);
  endtask

  task automatic test_conflict_diag();
    do_reset();
    btn_up = 1'b1;
    btn_down = 1'b1;
    tick(40);
    checks++; if (Y_POS !== 10'd240) begin errors++; $display("[TB] FAIL conflict_y got %0d exp 240", Y_POS); end
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(20);
    do_reset();
    btn_right = 1'b1;
    btn_down = 1'b1;
    tick(6);
    checks++; if ({X_POS, Y_POS} !== {10'd320, 10'd240}) begin errors++; $display("[TB] FAIL diag_pre got %0d,%0d exp 320,240", X_POS, Y_POS); end
    tick(1);
    checks++; if ({X_POS, Y_POS} !== {10'd321, 10'd241}) begin errors++; $display("[TB] FAIL diag_1 got %0d,%0d exp 321,241", X_POS, Y_POS); end
    tick(10);
    checks++; if ({X_POS, Y_POS} !== {10'd322, 10'd242}) begin errors++; $display("[TB] FAIL diag_2 got %0d,%0d exp 322,242", X_POS, Y_POS); end
    tick(3);
    checks++; if ({X_POS, Y_POS} !== {10'd323, 10'd243}) begin errors++; $display("[TB] FAIL diag_3 got %0d,%0d exp 323,243", X_POS, Y_POS); end
    btn_right = 1'b0;
    btn_down = 1'b0;
    tick(20);
  endtask

  task automatic test_color();
    logic [2:0] exp_prev;
    logic [2:0] exp_now;
    do_reset();
    exp_prev = 3'd7;
    for (int i = 0; i < 8; i++) begin
      exp_now = 3'(i);
      btn_color = 1'b1;
      tick(6);
      checks++; if (color !== exp_prev) begin errors++; $display("[TB] FAIL color_pre%0d got %0d exp %0d", i, color, exp_prev); end
      tick(1);
      checks++; if (color !== exp_now) begin errors++; $display("[TB] FAIL color_inc%0d got %0d exp %0d", i, color, exp_now); end
      tick(5);
      btn_color = 1'b0;
      tick(10);
      exp_prev = exp_now;
    end
  endtask

  task automatic test_switches();
    sw_tool = 1'b1;
    tick(1);
    checks++; if (tool_on !== 1'b0) begin errors++; $display("[TB] FAIL tool_lat1 got %0b exp 0", tool_on); end
    tick(1);
    checks++; if (tool_on !== 1'b1) begin errors++; $display("[TB] FAIL tool_lat2 got %0b exp 1", tool_on); end
    sw_size = 1'b1;
    tick(1);
    checks++; if (size_sel !== 1'b0) begin errors++; $display("[TB] FAIL size_lat1 got %0b exp 0", size_sel); end
    tick(1);
    checks++; if (size_sel !== 1'b1) begin errors++; $display("[TB] FAIL size_lat2 got %0b exp 1", size_sel); end
    sw_tool = 1'b0;
    sw_size = 1'b0;
    tick(3);
    checks++; if ({tool_on, size_sel} !== 2'b00) begin errors++; $display("[TB] FAIL sw_off got %b exp 00", {tool_on, size_sel}); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    btn_up = 1'b1;
    tick(23);
    checks++; if (Y_POS !== 10'd236) begin errors++; $display("[TB] FAIL mid_pre got %0d exp 236", Y_POS); end
    clr = 1'b0;
    tick(1);
    clr = 1'b1;
    checks++; if (Y_POS !== 10'd240) begin errors++; $display("[TB] FAIL mid_reset got %0d exp 240", Y_POS); end
    tick(6);
    checks++; if (Y_POS !== 10'd240) begin errors++; $display("[TB] FAIL mid_redb got %0d exp 240", Y_POS); end
    tick(1);
    checks++; if (Y_POS !== 10'd239) begin errors++; $display("[TB] FAIL mid_first got %0d exp 239", Y_POS); end
    tick(8);
    checks++; if (Y_POS !== 10'd239) begin errors++; $display("[TB] FAIL mid_single got %0d exp 239", Y_POS); end
    btn_up = 1'b0;
    tick(20);
  endtask

  initial begin
    clr = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    btn_color = 1'b0; sw_tool = 1'b0; sw_size = 1'b0;
    @(negedge clk);
    test_reset();
    test_tap();
    test_hold();
    test_clamp();
    test_conflict_diag();
    test_color();
    test_switches();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
